// File: rtl/regs_dbg_arbiter.sv
// rtl/regs_dbg_arbiter.sv - register file port arbiter between the core pipeline and a debug requester
module regs_dbg_arbiter #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    output logic [31:0] id_rs1_data_o,
    output logic [31:0] id_rs2_data_o,

    output logic [4:0]  rs1_raddr_o,
    output logic [4:0]  rs2_raddr_o,
    input  logic [31:0] rs1_rdata_i,
    input  logic [31:0] rs2_rdata_i,

    input  logic        ex_reg_wen_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic [31:0] ex_rd_data_i,

    output logic        regs_wen_o,
    output logic [4:0]  regs_waddr_o,
    output logic [31:0] regs_wdata_o,

    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [4:0]  dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    output logic        dbg_ack_o,
    output logic [31:0] dbg_rdata_o,

    output logic        hold_o
);

    // A drain length of 0 still spends one cycle in HOLD.
    localparam int LOAD_VAL = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
    localparam int CNT_W    = (LOAD_VAL < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_VAL);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_ACCESS = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [4:0]        r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;

    logic              w_accept;
    logic              w_dbg_go;
    logic              w_addr_is_x0;
    logic              w_cnt_last;

    // A request is accepted only from IDLE; debug inputs are ignored afterwards.
    assign w_accept     = (r_state == S_IDLE) && dbg_req_i;
    // The debug access fires only in an ACCESS cycle with no pipeline write-back.
    assign w_dbg_go     = (r_state == S_ACCESS) && !ex_reg_wen_i;
    assign w_addr_is_x0 = (r_addr == 5'd0);
    assign w_cnt_last   = (r_cnt == CNT_ONE);

    // Decode path and read port 2 are never arbitrated.
    assign id_rs1_data_o = rs1_rdata_i;
    assign id_rs2_data_o = rs2_rdata_i;
    assign rs2_raddr_o   = id_rs2_addr_i;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: drain in HOLD, wait out late write-backs in ACCESS.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (dbg_req_i) begin
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_cnt_last) begin
                    w_next_state = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!ex_reg_wen_i) begin
                    w_next_state = S_ACK;
                end
            end
            S_ACK: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Drain counter: loaded on accept, counts down through HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= CNT_ZERO;
        end else if (w_accept) begin
            r_cnt <= CNT_LOAD;
        end else if ((r_state == S_HOLD) && (r_cnt != CNT_ZERO)) begin
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

    // Request capture: the transaction uses only these latched fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= 5'd0;
            r_wdata <= 32'd0;
        end else if (w_accept) begin
            r_we    <= dbg_we_i;
            r_addr  <= dbg_addr_i;
            r_wdata <= dbg_wdata_i;
        end
    end

    // Debug result: read data, or an echo of the written value; x0 always reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 32'd0;
        end else if (w_dbg_go) begin
            if (w_addr_is_x0) begin
                r_rdata <= 32'd0;
            end else if (r_we) begin
                r_rdata <= r_wdata;
            end else begin
                r_rdata <= rs1_rdata_i;
            end
        end
    end

    assign dbg_rdata_o = r_rdata;

    // Output logic: pipeline passthrough except for the single debug access cycle.
    always_comb begin
        hold_o       = (r_state != S_IDLE);
        dbg_ack_o    = (r_state == S_ACK);
        rs1_raddr_o  = id_rs1_addr_i;
        regs_wen_o   = ex_reg_wen_i;
        regs_waddr_o = ex_rd_addr_i;
        regs_wdata_o = ex_rd_data_i;
        if (w_dbg_go) begin
            rs1_raddr_o  = r_addr;
            regs_wen_o   = r_we && !w_addr_is_x0;
            regs_waddr_o = r_addr;
            regs_wdata_o = r_wdata;
        end
    end

endmodule

// File: tb/tb_regs_dbg_arbiter.sv
// tb/tb_regs_dbg_arbiter.sv - randomized model-checked bench for regs_dbg_arbiter
module tb_regs_dbg_arbiter;

    localparam int DRAIN = 2;
    localparam int N     = (DRAIN < 1) ? 1 : DRAIN;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i;
    logic [31:0] id_rs1_data_o, id_rs2_data_o;
    logic [4:0]  rs1_raddr_o, rs2_raddr_o;
    logic [31:0] rs1_rdata_i, rs2_rdata_i;
    logic        ex_reg_wen_i;
    logic [4:0]  ex_rd_addr_i;
    logic [31:0] ex_rd_data_i;
    logic        regs_wen_o;
    logic [4:0]  regs_waddr_o;
    logic [31:0] regs_wdata_o;
    logic        dbg_req_i, dbg_we_i;
    logic [4:0]  dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_ack_o;
    logic [31:0] dbg_rdata_o;
    logic        hold_o;

    logic [31:0] rf [32];
    logic        force_ff;

    int n_checks;
    int n_fail;

    // transaction-level model: busy flag, drain cycles left, ack pending
    logic        m_busy, m_ack, m_we;
    int          m_drain;
    logic [4:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;

    logic        o_hold, o_ack, o_wen;

    regs_dbg_arbiter #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs1_data_o(id_rs1_data_o), .id_rs2_data_o(id_rs2_data_o),
        .rs1_raddr_o(rs1_raddr_o), .rs2_raddr_o(rs2_raddr_o),
        .rs1_rdata_i(rs1_rdata_i), .rs2_rdata_i(rs2_rdata_i),
        .ex_reg_wen_i(ex_reg_wen_i), .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_data_i(ex_rd_data_i),
        .regs_wen_o(regs_wen_o), .regs_waddr_o(regs_waddr_o), .regs_wdata_o(regs_wdata_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o),
        .hold_o(hold_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rs1_rdata_i = force_ff ? 32'hFFFF_FFFF : rf[rs1_raddr_o];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_ack = 1'b0; m_we = 1'b0; m_drain = 0;
        m_addr = 5'd0; m_wdata = 32'd0; m_rdata = 32'd0;
    endtask

    // Called at posedge+1 with inputs set; checks, crosses one edge, updates model and regfile.
    task automatic tick();
        logic        in_acc, dbg_go, exp_wen, env_wen;
        logic [4:0]  env_wa;
        logic [31:0] env_wd, rd_val;
        logic        n_busy, n_ack, n_we;
        int          n_drain;
        logic [4:0]  n_addr;
        logic [31:0] n_wdata, n_rdata;
        #3;
        in_acc  = m_busy && !m_ack && (m_drain == 0);
        dbg_go  = in_acc && !ex_reg_wen_i;
        exp_wen = dbg_go ? (m_we && (m_addr != 5'd0)) : ex_reg_wen_i;
        chk("hold_o", 32'(hold_o), 32'(m_busy));
        chk("dbg_ack_o", 32'(dbg_ack_o), 32'(m_ack));
        chk("dbg_rdata_o", dbg_rdata_o, m_rdata);
        chk("rs1_raddr_o", 32'(rs1_raddr_o), 32'(dbg_go ? m_addr : id_rs1_addr_i));
        chk("rs2_raddr_o", 32'(rs2_raddr_o), 32'(id_rs2_addr_i));
        chk("id_rs1_data_o", id_rs1_data_o, rs1_rdata_i);
        chk("id_rs2_data_o", id_rs2_data_o, rs2_rdata_i);
        chk("regs_wen_o", 32'(regs_wen_o), 32'(exp_wen));
        if (!dbg_go) begin
            chk("regs_waddr_o", 32'(regs_waddr_o), 32'(ex_rd_addr_i));
            chk("regs_wdata_o", regs_wdata_o, ex_rd_data_i);
        end else if (exp_wen) begin
            chk("regs_waddr_o_dbg", 32'(regs_waddr_o), 32'(m_addr));
            chk("regs_wdata_o_dbg", regs_wdata_o, m_wdata);
        end
        o_hold = hold_o; o_ack = dbg_ack_o; o_wen = regs_wen_o;
        env_wen = regs_wen_o; env_wa = regs_waddr_o; env_wd = regs_wdata_o;

        n_busy = m_busy; n_ack = m_ack; n_we = m_we; n_drain = m_drain;
        n_addr = m_addr; n_wdata = m_wdata; n_rdata = m_rdata;
        if (!m_busy) begin
            if (dbg_req_i) begin
                n_busy = 1'b1; n_drain = N;
                n_we = dbg_we_i; n_addr = dbg_addr_i; n_wdata = dbg_wdata_i;
            end
        end else if (m_ack) begin
            n_busy = 1'b0; n_ack = 1'b0;
        end else if (m_drain > 0) begin
            n_drain = m_drain - 1;
        end else if (!ex_reg_wen_i) begin
            rd_val  = force_ff ? 32'hFFFF_FFFF : rf[m_addr];
            n_rdata = (m_addr == 5'd0) ? 32'd0 : (m_we ? m_wdata : rd_val);
            n_ack   = 1'b1;
        end
        @(posedge clk);
        if (env_wen && (env_wa != 5'd0)) rf[env_wa] = env_wd;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_busy = n_busy; m_ack = n_ack; m_we = n_we; m_drain = n_drain;
            m_addr = n_addr; m_wdata = n_wdata; m_rdata = n_rdata;
        end
        #1;
    endtask

    task automatic dbg_txn(input logic we, input logic [4:0] a, input logic [31:0] d, input int late,
                           output int holds, output int ack_at, output int wens, output logic [31:0] rd);
        int left;
        left = late; holds = 0; ack_at = 0; wens = 0;
        dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = a; dbg_wdata_i = d; ex_reg_wen_i = 1'b0;
        tick();
        dbg_req_i = 1'b0;
        for (int i = 1; i <= 20 && ack_at == 0; i++) begin
            dbg_we_i = 1'($urandom); dbg_addr_i = 5'($urandom); dbg_wdata_i = $urandom;
            if (m_busy && !m_ack && m_drain == 0 && left > 0) begin
                ex_reg_wen_i = 1'b1; ex_rd_addr_i = 5'd4; ex_rd_data_i = 32'h55; left--;
            end else begin
                ex_reg_wen_i = 1'b0;
            end
            tick();
            if (o_hold) holds++;
            if (o_wen) wens++;
            if (o_ack) ack_at = i;
        end
        ex_reg_wen_i = 1'b0;
        chk("ack_timeout", 32'(ack_at != 0), 32'd1);
        rd = dbg_rdata_o;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk("rst_hold", 32'(hold_o), 32'd0);
        chk("rst_ack", 32'(dbg_ack_o), 32'd0);
        chk("rst_rdata", dbg_rdata_o, 32'd0);
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int h, a, w, ack1;
        logic [31:0] rd, keep9;
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; force_ff = 1'b0;
        id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0; rs2_rdata_i = 32'd0;
        ex_reg_wen_i = 1'b0; ex_rd_addr_i = 5'd0; ex_rd_data_i = 32'd0;
        dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = 5'd0; dbg_wdata_i = 32'd0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold", 32'(hold_o), 32'd0);
        chk("reset_ack", 32'(dbg_ack_o), 32'd0);
        chk("reset_rdata", dbg_rdata_o, 32'd0);
        rst_n = 1'b1;

        // idle passthrough
        id_rs1_addr_i = 5'd5; ex_reg_wen_i = 1'b1; ex_rd_addr_i = 5'd7; ex_rd_data_i = 32'h1234;
        #2;
        chk("idle_rs1_raddr", 32'(rs1_raddr_o), 32'd5);
        chk("idle_wen", 32'(regs_wen_o), 32'd1);
        chk("idle_waddr", 32'(regs_waddr_o), 32'd7);
        chk("idle_wdata", regs_wdata_o, 32'h1234);
        chk("idle_hold", 32'(hold_o), 32'd0);
        tick();
        ex_reg_wen_i = 1'b0;

        // debug read
        rf[3] = 32'hDEAD_BEEF;
        dbg_txn(1'b0, 5'd3, 32'd0, 0, h, a, w, rd);
        chk("rd_hold_cycles", 32'(h), 32'd4);
        chk("rd_ack_cycle", 32'(a), 32'd4);
        chk("rd_data", rd, 32'hDEAD_BEEF);
        tick();
        chk("rd_hold_dropped", 32'(o_hold), 32'd0);

        // debug write then read back
        dbg_txn(1'b1, 5'd10, 32'hA5A5_A5A5, 0, h, a, w, rd);
        chk("wr_wen_cycles", 32'(w), 32'd1);
        chk("wr_ack_cycle", 32'(a), 32'd4);
        chk("wr_echo", rd, 32'hA5A5_A5A5);
        chk("wr_rf10", rf[10], 32'hA5A5_A5A5);
        dbg_txn(1'b0, 5'd10, 32'd0, 0, h, a, w, rd);
        chk("rdback_x10", rd, 32'hA5A5_A5A5);

        // x0 handling
        dbg_txn(1'b1, 5'd0, 32'hCAFE_F00D, 0, h, a, w, rd);
        chk("x0_wr_wen", 32'(w), 32'd0);
        chk("x0_wr_echo", rd, 32'd0);
        dbg_txn(1'b0, 5'd10, 32'd0, 0, h, a, w, rd);
        force_ff = 1'b1;
        dbg_txn(1'b0, 5'd0, 32'd0, 0, h, a, w, rd);
        force_ff = 1'b0;
        chk("x0_rd_forced", rd, 32'd0);

        // late write-back during ACCESS
        dbg_txn(1'b0, 5'd3, 32'd0, 2, h, a, w, rd);
        chk("late_hold_cycles", 32'(h), 32'd6);
        chk("late_ack_cycle", 32'(a), 32'd6);
        chk("late_rd", rd, 32'hDEAD_BEEF);
        chk("late_x4", rf[4], 32'h55);

        // reset during HOLD
        keep9 = rf[9];
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd9; dbg_wdata_i = 32'h77;
        tick();
        dbg_req_i = 1'b0;
        tick();
        reset_pulse();
        w = 0;
        repeat (6) begin tick(); if (o_wen) w++; end
        chk("rst_no_dbg_write", 32'(w), 32'd0);
        chk("rst_x9_kept", rf[9], keep9);

        // back-to-back with req held through ACK
        rf[5] = 32'h5555_5555; rf[6] = 32'h6666_6666;
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd5;
        ack1 = 0;
        for (int i = 0; i < 20 && ack1 == 0; i++) begin tick(); if (o_ack) ack1 = 1; end
        chk("b2b_first_ack", 32'(ack1), 32'd1);
        chk("b2b_first_data", dbg_rdata_o, 32'h5555_5555);
        dbg_addr_i = 5'd6;
        tick();
        dbg_req_i = 1'b0;
        ack1 = 0;
        for (int i = 0; i < 20 && ack1 == 0; i++) begin tick(); if (o_ack) ack1 = i + 1; end
        chk("b2b_second_ack", 32'(ack1), 32'd4);
        chk("b2b_second_data", dbg_rdata_o, 32'h6666_6666);

        // randomized traffic checked against the model every cycle
        for (int c = 0; c < 3000; c++) begin
            id_rs1_addr_i = 5'($urandom); id_rs2_addr_i = 5'($urandom);
            rs2_rdata_i   = $urandom;
            ex_reg_wen_i  = ($urandom_range(0, 3) == 0);
            ex_rd_addr_i  = 5'($urandom); ex_rd_data_i = $urandom;
            dbg_req_i     = ($urandom_range(0, 5) == 0);
            dbg_we_i      = 1'($urandom);
            dbg_addr_i    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            dbg_wdata_i   = $urandom;
            if ($urandom_range(0, 299) == 0) reset_pulse();
            else tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
